// File: rtl/mips_pkg.sv
// Shared MIPS constants: register file geometry, architectural register
// indices and the reset values of $gp/$sp used by the loader and the bench.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] GP_RESET = 32'h1000_8000;
  localparam logic [31:0] SP_RESET = 32'h7FFF_FFFC;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: selects an entry,
// forces index 0 to read zero, and (when REGFILE_BYPASS_EN is defined)
// forwards the in-flight write data for a matching index.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                idx_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_idx_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  output logic [DATA_W-1:0]                data_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

`ifndef REGFILE_BYPASS_EN
  // Without the bypass the write-side inputs have no effect on the read.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_idx_i, wr_data_i};
`endif

  // Select stored value, optionally forward the write, then hardwire r0.
  always_comb begin
    data_o = regs_i[idx_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && (wr_idx_i == idx_i)) begin
      data_o = wr_data_i;
    end
`endif
    if (idx_i == ZERO_IDX) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two operand read ports,
// a debug read port and one synchronous write port with a commit counter.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to every read port whose index matches the write index.
module register_file #(
  parameter int                    DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = mips_pkg::GP_RESET,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = mips_pkg::SP_RESET
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] dbgRegister,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] dbgData,
  output logic [31:0]           writeCount
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] GP_IDX = ADDR_WIDTH'(mips_pkg::REG_GP);
  localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(mips_pkg::REG_SP);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [31:0]                         write_count_q, write_count_d;
  logic                                wr_commit;
  logic                                wr_live;

  // r0 writes are dropped entirely; they neither store nor count.
  assign wr_commit = regWrite && (writeRegister != '0);
  // Forwarding is suppressed while reset holds the array at its reset image.
  assign wr_live   = regWrite && rstN;

  // Next-state for the storage array and the commit counter.
  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (wr_commit) begin
      regs_d[writeRegister] = writeData;
      write_count_d         = write_count_q + 32'd1;
    end
  end

  // Storage and counter; reset loads $gp/$sp and clears everything else.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      regs_q         <= '0;
      regs_q[GP_IDX] <= GP_RESET;
      regs_q[SP_IDX] <= SP_RESET;
      write_count_q  <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  assign writeCount = write_count_q;

  regfile_read_port #(.DATA_W(DATA_WIDTH), .ADDR_W(ADDR_WIDTH)) u_rd1 (
    .regs_i    (regs_q),
    .idx_i     (readRegister1),
    .wr_en_i   (wr_live),
    .wr_idx_i  (writeRegister),
    .wr_data_i (writeData),
    .data_o    (readData1)
  );

  regfile_read_port #(.DATA_W(DATA_WIDTH), .ADDR_W(ADDR_WIDTH)) u_rd2 (
    .regs_i    (regs_q),
    .idx_i     (readRegister2),
    .wr_en_i   (wr_live),
    .wr_idx_i  (writeRegister),
    .wr_data_i (writeData),
    .data_o    (readData2)
  );

  regfile_read_port #(.DATA_W(DATA_WIDTH), .ADDR_W(ADDR_WIDTH)) u_dbg (
    .regs_i    (regs_q),
    .idx_i     (dbgRegister),
    .wr_en_i   (wr_live),
    .wr_idx_i  (writeRegister),
    .wr_data_i (writeData),
    .data_o    (dbgData)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected port values,
// a negedge monitor pops and compares them against the live outputs.
module tb_register_file;
  import mips_pkg::*;

  logic        clk;
  logic        rstN;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  dbgRegister;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] dbgData;
  logic [31:0] writeCount;

  register_file dut (
    .clk           (clk),
    .rstN          (rstN),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .dbgRegister   (dbgRegister),
    .readData1     (readData1),
    .readData2     (readData2),
    .dbgData       (dbgData),
    .writeCount    (writeCount)
  );

  // Clock starts high so the first negedge (5 ns) precedes the first posedge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  localparam int P_RD1 = 0;
  localparam int P_RD2 = 1;
  localparam int P_DBG = 2;
  localparam int P_CNT = 3;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  exp_t        mon_e;
  logic [31:0] mon_act;

  task automatic push(input string name, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] reset_val(input int idx);
    if (idx == REG_GP) return GP_RESET;
    if (idx == REG_SP) return SP_RESET;
    return 32'h0;
  endfunction

  // Monitor: every expectation queued in a cycle is checked at its negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.port)
        P_RD1:   mon_act = readData1;
        P_RD2:   mon_act = readData2;
        P_DBG:   mon_act = dbgData;
        default: mon_act = writeCount;
      endcase
      tests_run++;
      if (mon_act !== mon_e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    regWrite      = we;
    writeRegister = wa;
    writeData     = wd;
    readRegister1 = r1;
    readRegister2 = r2;
    dbgRegister   = rd;
  endtask

  initial begin
    rstN = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Reset asserted mid-cycle, before any clock edge.
    #2;
    rstN = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd28, 5'd29, 5'd0);
    push("rst_noedge_r28", P_RD1, 32'h1000_8000);
    push("rst_noedge_r29", P_RD2, 32'h7FFF_FFFC);
    push("rst_noedge_r0",  P_DBG, 32'h0);
    push("rst_noedge_cnt", P_CNT, 32'h0);

    // Sweep every index on all three read ports while reset is held.
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      push($sformatf("rst_rd1_r%0d", i), P_RD1, reset_val(i));
      push($sformatf("rst_rd2_r%0d", 31 - i), P_RD2, reset_val(31 - i));
      push($sformatf("rst_dbg_r%0d", i), P_DBG, reset_val(i));
    end
    push("rst_cnt", P_CNT, 32'h0);

    // Release reset; write r5 on the next edge.
    next_cycle();
    rstN = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 5'd5, 32'h1111_1111, 5'd5, 5'd5, 5'd5);
    push("wr_r5_rd1", P_RD1, 32'hDEAD_BEEF);
    push("wr_r5_rd2", P_RD2, 32'hDEAD_BEEF);
    push("wr_r5_dbg", P_DBG, 32'hDEAD_BEEF);
    push("wr_r5_cnt", P_CNT, 32'd1);
    // regWrite=0 in the previous cycle: r5 unchanged.
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0);
    push("nowe_r5", P_RD1, 32'hDEAD_BEEF);
    push("nowe_cnt", P_CNT, 32'd1);

    // Write to r0 while reading index 0 on all ports, same cycle and after.
    next_cycle();
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    push("r0_pre_rd1", P_RD1, 32'h0);
    push("r0_pre_rd2", P_RD2, 32'h0);
    push("r0_pre_dbg", P_DBG, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    push("r0_post_rd1", P_RD1, 32'h0);
    push("r0_post_rd2", P_RD2, 32'h0);
    push("r0_post_dbg", P_DBG, 32'h0);
    push("r0_post_cnt", P_CNT, 32'd1);

    // r7 = 1, then same-cycle write AAAA5555 and read r7.
    next_cycle();
    drive(1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, 5'd7, 32'hAAAA_5555, 5'd7, 5'd5, 5'd7);
`ifdef REGFILE_BYPASS_EN
    push("rw_same_pre_rd1", P_RD1, 32'hAAAA_5555);
    push("rw_same_pre_dbg", P_DBG, 32'hAAAA_5555);
`else
    push("rw_same_pre_rd1", P_RD1, 32'h0000_0001);
    push("rw_same_pre_dbg", P_DBG, 32'h0000_0001);
`endif
    push("rw_same_other_rd2", P_RD2, 32'hDEAD_BEEF);
    push("rw_same_pre_cnt", P_CNT, 32'd2);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd5);
    push("rw_same_post_rd1", P_RD1, 32'hAAAA_5555);
    push("rw_same_post_rd2", P_RD2, 32'hAAAA_5555);
    push("rw_same_post_dbg", P_DBG, 32'hDEAD_BEEF);
    push("rw_same_post_cnt", P_CNT, 32'd3);

    // Highest index r31.
    next_cycle();
    drive(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd30, 5'd31, 5'd31);
    push("r31_rd1_r30", P_RD1, 32'h0);
    push("r31_rd2", P_RD2, 32'hFFFF_FFFF);
    push("r31_dbg", P_DBG, 32'hFFFF_FFFF);
    push("r31_cnt", P_CNT, 32'd4);

    // r9 = 42h, then reset for one cycle with a write pending on r9.
    next_cycle();
    drive(1'b1, 5'd9, 32'h0000_0042, 5'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd0);
    push("r9_written", P_RD1, 32'h0000_0042);
    push("r9_cnt", P_CNT, 32'd5);
    next_cycle();
    rstN = 1'b0;
    drive(1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd29, 5'd7);
    push("rst2_r9", P_RD1, 32'h0);
    push("rst2_r29", P_RD2, 32'h7FFF_FFFC);
    push("rst2_r7", P_DBG, 32'h0);
    push("rst2_cnt", P_CNT, 32'd0);
    // The edge above happened with rstN low; release and write r3 at once.
    next_cycle();
    rstN = 1'b1;
    drive(1'b1, 5'd3, 32'h0000_0033, 5'd9, 5'd7, 5'd3);
    push("rst2_ign_r9", P_RD1, 32'h0);
    push("rst2_ign_r7", P_RD2, 32'h0);
    push("rst2_ign_cnt", P_CNT, 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd28, 5'd0);
    push("first_wr_r3", P_RD1, 32'h0000_0033);
    push("first_wr_r28", P_RD2, 32'h1000_8000);
    push("first_wr_cnt", P_CNT, 32'd1);

    // Counter wrap: preload all-ones, then one committed write.
    next_cycle();
    force dut.write_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.write_count_q;
    drive(1'b1, 5'd4, 32'h0000_0044, 5'd0, 5'd0, 5'd0);
    push("wrap_pre_cnt", P_CNT, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd29, 5'd29);
    push("wrap_cnt", P_CNT, 32'h0);
    push("same_r29_rd1", P_RD1, 32'h7FFF_FFFC);
    push("same_r29_rd2", P_RD2, 32'h7FFF_FFFC);
    push("same_r29_dbg", P_DBG, 32'h7FFF_FFFC);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 5'd0);
    push("wrap_r4", P_RD1, 32'h0000_0044);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
